smi_header_arb: RTL

SMI_HEADER_ARB -- requirements
Module: smi_header_arb

---
 rtl/smi_header_arb_pkg.sv | 14 +
 rtl/smi_header_arb_rr_pick.sv | 20 ++
 rtl/smi_header_arb.sv | 129 ++++++++++++
 3 files changed

// File: rtl/smi_header_arb_pkg.sv
// Shared definitions for the SMI header arbiter.
//   NumPorts   - number of requesters sharing the injector (fixed at 2)
//   arbState_t - arbiter phase: idle, forwarding header, forwarding frame
package smi_header_arb_pkg;

  localparam int NumPorts = 2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HEADER = 2'd1,
    ARB_FRAME  = 2'd2
  } arbState_t;

endpackage

// File: rtl/smi_header_arb_rr_pick.sv
// Two-way round-robin selector.
// Ports:
//   req       - request vector, one bit per port
//   lastGrant - port served most recently; loses a tie
//   pickValid - at least one request present
//   pickId    - chosen port (0 when nothing requests)
module smi_rr_pick
  import smi_header_arb_pkg::*;
(
  input  logic [NumPorts-1:0] req,
  input  logic                lastGrant,
  output logic                pickValid,
  output logic                pickId
);

  // Single requester wins outright; on a tie the port not served last wins.
  assign pickValid = |req;
  assign pickId    = (req == 2'b11) ? ~lastGrant : req[1];

endmodule

// File: rtl/smi_header_arb.sv
// Arbitrates two header+frame requesters onto one shared injector link.
// A requester is granted on its header, keeps the grant through the frame
// until the flit carrying nonzero eofc transfers, then the arbiter idles
// one cycle before granting again.
// Ports:
//   clk, srst                     - clock, async active-low reset
//   hdrReady/hdrData/hdrStop      - per-port header links (packed, port 0 in LSBs)
//   smiInReady/Eofc/Data/Stop     - per-port flit links (packed, port 0 in LSBs)
//   headerReady/Data/Stop         - shared header output
//   smiOutReady/Eofc/Data/Stop    - shared flit output
//   grantValid/grantId            - arbitration status
//
// state      | meaning
// ARB_IDLE   | no owner; all inputs held off, pick a requester
// ARB_HEADER | owner's header routed to headerReady/headerData
// ARB_FRAME  | owner's flits routed until the eofc flit transfers
module smi_header_arb
  import smi_header_arb_pkg::*;
#(
  parameter int FlitWidth = 16,
  parameter int HeadWidth = 4
) (
  input  logic                            clk,
  input  logic                            srst,
  input  logic [NumPorts-1:0]             hdrReady,
  input  logic [NumPorts*HeadWidth*8-1:0] hdrData,
  output logic [NumPorts-1:0]             hdrStop,
  input  logic [NumPorts-1:0]             smiInReady,
  input  logic [NumPorts*8-1:0]           smiInEofc,
  input  logic [NumPorts*FlitWidth*8-1:0] smiInData,
  output logic [NumPorts-1:0]             smiInStop,
  output logic                            headerReady,
  output logic [HeadWidth*8-1:0]          headerData,
  input  logic                            headerStop,
  output logic                            smiOutReady,
  output logic [7:0]                      smiOutEofc,
  output logic [FlitWidth*8-1:0]          smiOutData,
  input  logic                            smiOutStop,
  output logic                            grantValid,
  output logic                            grantId
);

  localparam int HB = HeadWidth * 8;
  localparam int FB = FlitWidth * 8;

  arbState_t state;
  logic      lastGrant;
  logic      pickValid;
  logic      pickId;

  logic [HB-1:0] selHdrData;
  logic [7:0]    selEofc;
  logic [FB-1:0] selData;
  logic          hdrXfer;
  logic          lastFlitXfer;

  smi_rr_pick uPick (
    .req       (hdrReady),
    .lastGrant (lastGrant),
    .pickValid (pickValid),
    .pickId    (pickId)
  );

  assign selHdrData = grantId ? hdrData[2*HB-1:HB]      : hdrData[HB-1:0];
  assign selEofc    = grantId ? smiInEofc[15:8]         : smiInEofc[7:0];
  assign selData    = grantId ? smiInData[2*FB-1:FB]    : smiInData[FB-1:0];

  assign hdrXfer      = hdrReady[grantId] & ~headerStop;
  assign lastFlitXfer = smiInReady[grantId] & ~smiOutStop & (selEofc != 8'd0);

  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      state      <= ARB_IDLE;
      grantId    <= 1'b0;
      lastGrant  <= 1'b1;
      grantValid <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pickValid) begin
            grantId    <= pickId;
            grantValid <= 1'b1;
            state      <= ARB_HEADER;
          end
        end
        ARB_HEADER: begin
          if (hdrXfer) state <= ARB_FRAME;
        end
        ARB_FRAME: begin
          if (lastFlitXfer) begin
            lastGrant  <= grantId;
            grantValid <= 1'b0;
            state      <= ARB_IDLE;
          end
        end
        default: begin
          grantValid <= 1'b0;
          state      <= ARB_IDLE;
        end
      endcase
    end
  end

  // Anything not currently routed sees Stop equal to its own Ready, so it holds.
  always_comb begin
    hdrStop     = hdrReady;
    smiInStop   = smiInReady;
    headerReady = 1'b0;
    headerData  = '0;
    smiOutReady = 1'b0;
    smiOutEofc  = 8'd0;
    smiOutData  = '0;
    case (state)
      ARB_HEADER: begin
        headerReady       = hdrReady[grantId];
        headerData        = selHdrData;
        hdrStop[grantId]  = hdrReady[grantId] & headerStop;
      end
      ARB_FRAME: begin
        smiOutReady        = smiInReady[grantId];
        smiOutEofc         = selEofc;
        smiOutData         = selData;
        smiInStop[grantId] = smiInReady[grantId] & smiOutStop;
      end
      default: ;
    endcase
  end

endmodule
